fft_pair_ctrl: RTL and testbench
================================

Name: fft_pair_ctrl

Overview:
- Control-only sequencer for one radix-2 FFT stage that pairs beat k with beat k+HALF of a frame.
- A frame is NUM_BEAT beats; each beat is one ARRAY-wide vector already carried by the datapath.
- The block drives the stage's half-frame register bank (addresses, write enable) and the u/v select of the downstream 2-way vector mux.
- First half is buffered, second half emits sums (u path) while differences are written back, then the differences are drained (v path).

Parameters:
NUM_BEAT, 32, beats per frame; power of two, >=4
AW, $clog2(NUM_BEAT/2), buffer address width
FCW, 16, frame counter width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
flush  in  1  synchronous abort, returns to IDLE
din_valid  in  1  input beat valid
din_ready  out  1  input beat accepted when din_valid&din_ready
dout_ready  in  1  downstream can take a beat
dout_valid  out  1  output beat valid
sel  out  1  mux select: 0=u (butterfly sum), 1=v (buffer readback)
buf_wr_en  out  1  half-frame buffer write strobe
buf_wr_addr  out  AW  buffer write address
buf_rd_addr  out  AW  buffer read address (bank has combinational read)
bfly_en  out  1  butterfly operands valid this cycle
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse on last drained beat
frame_cnt  out  FCW  completed frames, wraps

Behaviour:
- HALF = NUM_BEAT/2. Registered state: fsm, cnt[AW-1:0], frame_cnt. All other outputs decode combinationally from state, cnt and handshakes in the same cycle.
- Reset (rstn low, async): fsm=IDLE, cnt=0, frame_cnt=0. Outputs read: din_ready=1, dout_valid=0, sel=0, buf_wr_en=0, addrs=0, bfly_en=0, busy=0, frame_done=0.
- IDLE:
  - din_ready=1.
  - Accept: buf_wr_en=1, wr_addr=0, cnt<=1, go FILL.
  - If HALF==1 is impossible (NUM_BEAT>=4), so this path always enters FILL.
- FILL: din_ready=1, busy=1.
  - Accept: buf_wr_en=1, wr_addr=cnt.
  - When cnt==HALF-1: cnt<=0, go PAIR. Else cnt++.
  - No accept: hold.
- PAIR: busy=1, din_ready=dout_ready, sel=0, rd_addr=cnt.
  - dout_valid=din_valid; bfly_en=din_valid.
  - On accept (din_valid&dout_ready): buf_wr_en=1, wr_addr=cnt (difference overwrites its operand).
  - When cnt==HALF-1: cnt<=0, go DRAIN. Else cnt++.
- DRAIN: busy=1, din_ready=0, sel=1, rd_addr=cnt, dout_valid=1.
  - On dout_ready: when cnt==HALF-1: frame_done=1, frame_cnt++, cnt<=0, go IDLE. Else cnt++.
  - No dout_ready: hold, outputs stable.
- Input throughput: NUM_BEAT beats in, NUM_BEAT beats out. Minimum frame period is NUM_BEAT+HALF cycles. First output appears in the same cycle as input beat HALF.
- flush (sync, priority over all else, any state): next cycle fsm=IDLE, cnt=0, frame_cnt unchanged.
  - In the flush cycle: buf_wr_en=0, dout_valid=0, din_ready=0, frame_done=0.
- Async reset mid-frame: immediate return to reset values. The partial frame is discarded and no frame_done is issued.
- frame_cnt wraps from 2^FCW-1 to 0.
- Buffer data content is not reset; only write order matters.

Test Plan (NUM_BEAT=8, HALF=4):
- Single frame, din_valid and dout_ready held 1 -> wr_addr 0,1,2,3 in FILL; in PAIR sel=0, rd/wr_addr 0..3, dout_valid on 4 cycles; in DRAIN sel=1, rd_addr 0..3; frame_done high on cycle 12 after first accept; frame_cnt=1; din_ready=0 for exactly 4 DRAIN cycles.
- din_valid toggled 1/0 in FILL/PAIR -> cnt advances only on accepts; buf_wr_en never asserts while din_valid=0; beat order and addresses are identical to the first scenario.
- dout_ready=0 for 3 cycles mid-PAIR at cnt=2 -> din_ready=0, no writes, cnt holds 2; 3 cycles of dout_ready=0 mid-DRAIN at cnt=1 -> rd_addr holds 1, dout_valid stays 1.
- flush asserted at PAIR cnt=2 -> flush cycle shows dout_valid=0 and buf_wr_en=0; then IDLE, busy=0, frame_cnt unchanged; the next frame runs cleanly.
- rstn pulsed low mid-DRAIN -> all outputs reach reset values without a clock edge; no frame_done is issued.
- FCW=2, 5 back-to-back frames -> frame_cnt sequence 1,2,3,0,1; one frame_done per frame.

Source files
------------

// File: rtl/fft_pair_ctrl.sv
// Control sequencer for one radix-2 FFT stage that pairs beat k with beat k+HALF.
// The first half-frame is buffered. During the second half, sums go out on the u path
// while differences overwrite their operands. The buffered differences are then drained on the v path.
module fft_pair_ctrl #(
  parameter int unsigned NUM_BEAT = 32,
  parameter int unsigned AW       = $clog2(NUM_BEAT / 2),
  parameter int unsigned FCW      = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           flush,
  input  logic           din_valid,
  output logic           din_ready,
  input  logic           dout_ready,
  output logic           dout_valid,
  output logic           sel,
  output logic           buf_wr_en,
  output logic [AW-1:0]  buf_wr_addr,
  output logic [AW-1:0]  buf_rd_addr,
  output logic           bfly_en,
  output logic           busy,
  output logic           frame_done,
  output logic [FCW-1:0] frame_cnt
);

  localparam int unsigned HALF = NUM_BEAT / 2;
  localparam logic [AW-1:0] LAST_IDX = AW'(HALF - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    PAIR  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [AW-1:0]  cnt;
  logic [AW-1:0]  cnt_nxt;
  logic [FCW-1:0] frame_cnt_nxt;
  logic           cnt_last;

  assign cnt_last = (cnt == LAST_IDX);

  // State, beat index and completed-frame counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      frame_cnt <= frame_cnt_nxt;
    end
  end

  // Next-state and same-cycle output decode from state, index and handshakes
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    frame_cnt_nxt = frame_cnt;
    din_ready     = 1'b0;
    dout_valid    = 1'b0;
    sel           = 1'b0;
    buf_wr_en     = 1'b0;
    buf_wr_addr   = '0;
    buf_rd_addr   = '0;
    bfly_en       = 1'b0;
    busy          = 1'b0;
    frame_done    = 1'b0;

    case (state)
      IDLE: begin
        din_ready = 1'b1;
        if (din_valid) begin
          // Beat 0 of the frame lands at address 0; HALF >= 2 so FILL always follows
          buf_wr_en   = 1'b1;
          buf_wr_addr = '0;
          cnt_nxt     = AW'(1);
          state_nxt   = FILL;
        end
      end

      FILL: begin
        din_ready = 1'b1;
        busy      = 1'b1;
        if (din_valid) begin
          buf_wr_en   = 1'b1;
          buf_wr_addr = cnt;
          if (cnt_last) begin
            cnt_nxt   = '0;
            state_nxt = PAIR;
          end else begin
            cnt_nxt = cnt + AW'(1);
          end
        end
      end

      PAIR: begin
        // Input and output move together: a beat is only taken when its sum can leave
        busy        = 1'b1;
        din_ready   = dout_ready;
        sel         = 1'b0;
        buf_rd_addr = cnt;
        dout_valid  = din_valid;
        bfly_en     = din_valid;
        if (din_valid && dout_ready) begin
          // Difference overwrites the operand it was computed from
          buf_wr_en   = 1'b1;
          buf_wr_addr = cnt;
          if (cnt_last) begin
            cnt_nxt   = '0;
            state_nxt = DRAIN;
          end else begin
            cnt_nxt = cnt + AW'(1);
          end
        end
      end

      DRAIN: begin
        busy        = 1'b1;
        sel         = 1'b1;
        buf_rd_addr = cnt;
        dout_valid  = 1'b1;
        if (dout_ready) begin
          if (cnt_last) begin
            frame_done    = 1'b1;
            frame_cnt_nxt = frame_cnt + FCW'(1);
            cnt_nxt       = '0;
            state_nxt     = IDLE;
          end else begin
            cnt_nxt = cnt + AW'(1);
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Abort overrides everything: no handshake or write completes this cycle
    if (flush) begin
      din_ready     = 1'b0;
      dout_valid    = 1'b0;
      buf_wr_en     = 1'b0;
      frame_done    = 1'b0;
      state_nxt     = IDLE;
      cnt_nxt       = '0;
      frame_cnt_nxt = frame_cnt;
    end
  end

endmodule

// File: tb/tb_fft_pair_ctrl.sv
// Bench for fft_pair_ctrl with NUM_BEAT=8 (HALF=4) and FCW=2, so frame_cnt wraps early.
module tb_fft_pair_ctrl;

  localparam int unsigned NUM_BEAT = 8;
  localparam int unsigned AW       = 2;
  localparam int unsigned FCW      = 2;

  logic           clk;
  logic           rstn;
  logic           flush;
  logic           din_valid;
  logic           din_ready;
  logic           dout_ready;
  logic           dout_valid;
  logic           sel;
  logic           buf_wr_en;
  logic [AW-1:0]  buf_wr_addr;
  logic [AW-1:0]  buf_rd_addr;
  logic           bfly_en;
  logic           busy;
  logic           frame_done;
  logic [FCW-1:0] frame_cnt;

  fft_pair_ctrl #(
    .NUM_BEAT(NUM_BEAT),
    .AW      (AW),
    .FCW     (FCW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout_ready (dout_ready),
    .dout_valid (dout_valid),
    .sel        (sel),
    .buf_wr_en  (buf_wr_en),
    .buf_wr_addr(buf_wr_addr),
    .buf_rd_addr(buf_rd_addr),
    .bfly_en    (bfly_en),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of expected behaviour: driven inputs, then required outputs
  typedef struct packed {
    logic           dv;
    logic           dr;
    logic           e_din_ready;
    logic           e_dout_valid;
    logic           e_sel;
    logic           e_wr_en;
    logic [AW-1:0]  e_wa;
    logic [AW-1:0]  e_ra;
    logic           e_bfly;
    logic           e_busy;
    logic           e_done;
    logic [FCW-1:0] e_fc;
  } vec_t;

  typedef struct packed {
    logic          s;
    logic [AW-1:0] a;
  } ob_t;

  int          n_checks;
  int          n_fail;
  bit          sb_on;
  logic [AW-1:0] wq[$];
  ob_t         oq[$];
  vec_t        tab[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_din_ready"},  32'(din_ready),   32'd1);
    chk({tag, "_dout_valid"}, 32'(dout_valid),  32'd0);
    chk({tag, "_sel"},        32'(sel),         32'd0);
    chk({tag, "_wr_en"},      32'(buf_wr_en),   32'd0);
    chk({tag, "_wr_addr"},    32'(buf_wr_addr), 32'd0);
    chk({tag, "_rd_addr"},    32'(buf_rd_addr), 32'd0);
    chk({tag, "_bfly"},       32'(bfly_en),     32'd0);
    chk({tag, "_busy"},       32'(busy),        32'd0);
    chk({tag, "_done"},       32'(frame_done),  32'd0);
    chk({tag, "_frame_cnt"},  32'(frame_cnt),   32'd0);
  endtask

  // Expected write order and output beat order for one whole frame
  task automatic push_frame();
    for (int i = 0; i < 4; i++) wq.push_back(AW'(i));
    for (int i = 0; i < 4; i++) wq.push_back(AW'(i));
    for (int i = 0; i < 4; i++) oq.push_back('{s: 1'b0, a: AW'(i)});
    for (int i = 0; i < 4; i++) oq.push_back('{s: 1'b1, a: AW'(i)});
  endtask

  task automatic sb_mon();
    logic [AW-1:0] ew;
    ob_t           eo;
    if (buf_wr_en) begin
      chk("wr_only_on_accept", 32'(din_valid & din_ready), 32'd1);
      if (wq.size() == 0) begin
        chk("wr_unexpected", 32'(buf_wr_addr), 32'hFFFF);
      end else begin
        ew = wq.pop_front();
        chk("wr_addr_order", 32'(buf_wr_addr), 32'(ew));
      end
    end
    if (dout_valid && dout_ready) begin
      if (oq.size() == 0) begin
        chk("out_unexpected", 32'({sel, buf_rd_addr}), 32'hFFFF);
      end else begin
        eo = oq.pop_front();
        chk("out_sel_addr", 32'({sel, buf_rd_addr}), 32'(eo));
      end
    end
  endtask

  task automatic sample(input logic dv, input logic dr, input logic fl);
    din_valid  = dv;
    dout_ready = dr;
    flush      = fl;
    @(negedge clk);
    if (sb_on) sb_mon();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sb_empty(input string tag);
    chk({tag, "_wq_left"}, 32'(wq.size()), 32'd0);
    chk({tag, "_oq_left"}, 32'(oq.size()), 32'd0);
    wq.delete();
    oq.delete();
  endtask

  // Full frame with dout_ready held high; optionally toggle din_valid every cycle
  task automatic run_frame(input bit toggle, input string tag);
    bit done;
    done = 1'b0;
    push_frame();
    sb_on = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      sample(toggle ? logic'(c % 2 == 0) : 1'b1, 1'b1, 1'b0);
      if (frame_done) done = 1'b1;
      adv();
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk_sb_empty(tag);
    sb_on = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rstn = 1'b1;
    adv();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int      done_cnt;
    int      last_done;
    bit      pend;
    logic [FCW-1:0] exp_fc[5];

    n_checks   = 0;
    n_fail     = 0;
    sb_on      = 1'b0;
    flush      = 1'b0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;

    //            dv    dr    drdy  dval  sel   we    wa     ra     bfly  busy  done  fc
    tab[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0};
    tab[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0};
    tab[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0};
    tab[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0};
    tab[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0};
    tab[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 2'd1, 1'b1, 1'b1, 1'b0, 2'd0};
    tab[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 2'd2, 1'b1, 1'b1, 1'b0, 2'd0};
    tab[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 2'd3, 1'b1, 1'b1, 1'b0, 2'd0};
    tab[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0};
    tab[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 2'd0};
    tab[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0, 2'd0};
    tab[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd3, 1'b0, 1'b1, 1'b1, 2'd0};
    tab[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1};

    exp_fc[0] = 2'd1;
    exp_fc[1] = 2'd2;
    exp_fc[2] = 2'd3;
    exp_fc[3] = 2'd0;
    exp_fc[4] = 2'd1;

    do_reset();

    // Frame 1: cycle-exact table with both handshakes held high
    push_frame();
    sb_on = 1'b1;
    for (int i = 0; i < 13; i++) begin
      sample(tab[i].dv, tab[i].dr, 1'b0);
      chk($sformatf("row%0d_din_ready", i),  32'(din_ready),   32'(tab[i].e_din_ready));
      chk($sformatf("row%0d_dout_valid", i), 32'(dout_valid),  32'(tab[i].e_dout_valid));
      chk($sformatf("row%0d_sel", i),        32'(sel),         32'(tab[i].e_sel));
      chk($sformatf("row%0d_wr_en", i),      32'(buf_wr_en),   32'(tab[i].e_wr_en));
      chk($sformatf("row%0d_wr_addr", i),    32'(buf_wr_addr), 32'(tab[i].e_wa));
      chk($sformatf("row%0d_rd_addr", i),    32'(buf_rd_addr), 32'(tab[i].e_ra));
      chk($sformatf("row%0d_bfly", i),       32'(bfly_en),     32'(tab[i].e_bfly));
      chk($sformatf("row%0d_busy", i),       32'(busy),        32'(tab[i].e_busy));
      chk($sformatf("row%0d_done", i),       32'(frame_done),  32'(tab[i].e_done));
      chk($sformatf("row%0d_frame_cnt", i),  32'(frame_cnt),   32'(tab[i].e_fc));
      adv();
    end
    chk_sb_empty("table");
    sb_on = 1'b0;

    // Frame 2: din_valid toggling, same write and output order
    run_frame(1'b1, "toggle");
    sample(1'b0, 1'b1, 1'b0);
    chk("toggle_frame_cnt", 32'(frame_cnt), 32'd2);
    adv();

    // Frame 3: downstream stalls mid-PAIR at index 2 and mid-DRAIN at index 1
    push_frame();
    sb_on = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sample(1'b1, 1'b1, 1'b0);
      adv();
    end
    for (int i = 0; i < 3; i++) begin
      sample(1'b1, 1'b0, 1'b0);
      chk("pair_stall_din_ready", 32'(din_ready),   32'd0);
      chk("pair_stall_wr_en",     32'(buf_wr_en),   32'd0);
      chk("pair_stall_rd_addr",   32'(buf_rd_addr), 32'd2);
      chk("pair_stall_sel",       32'(sel),         32'd0);
      adv();
    end
    sample(1'b1, 1'b1, 1'b0);
    chk("pair_resume_wr_addr", 32'(buf_wr_addr), 32'd2);
    chk("pair_resume_wr_en",   32'(buf_wr_en),    32'd1);
    adv();
    sample(1'b1, 1'b1, 1'b0);
    adv();
    sample(1'b1, 1'b1, 1'b0);
    chk("drain0_sel", 32'({sel, buf_rd_addr}), 32'h4);
    adv();
    for (int i = 0; i < 3; i++) begin
      sample(1'b1, 1'b0, 1'b0);
      chk("drain_stall_rd_addr",   32'(buf_rd_addr), 32'd1);
      chk("drain_stall_dout_valid", 32'(dout_valid), 32'd1);
      chk("drain_stall_sel",       32'(sel),         32'd1);
      chk("drain_stall_done",      32'(frame_done),  32'd0);
      chk("drain_stall_din_ready", 32'(din_ready),   32'd0);
      adv();
    end
    sample(1'b1, 1'b1, 1'b0);
    adv();
    sample(1'b1, 1'b1, 1'b0);
    adv();
    sample(1'b1, 1'b1, 1'b0);
    chk("stall_last_rd_addr", 32'(buf_rd_addr), 32'd3);
    chk("stall_last_done",    32'(frame_done),   32'd1);
    adv();
    sample(1'b0, 1'b1, 1'b0);
    chk("stall_frame_cnt", 32'(frame_cnt), 32'd3);
    chk("stall_idle_busy", 32'(busy),      32'd0);
    adv();
    chk_sb_empty("stall");
    sb_on = 1'b0;

    // Async reset while draining index 1: outputs return without a clock edge
    for (int i = 0; i < 9; i++) begin
      sample(1'b1, 1'b1, 1'b0);
      adv();
    end
    din_valid = 1'b0;
    #1;
    chk("pre_reset_drain", 32'({sel, buf_rd_addr}), 32'h5);
    rstn = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("in_reset_done", 32'(frame_done), 32'd0);
      chk("in_reset_busy", 32'(busy),       32'd0);
    end
    rstn = 1'b1;
    adv();

    // Flush at PAIR index 2 discards the frame and keeps frame_cnt
    for (int i = 0; i < 6; i++) begin
      sample(1'b1, 1'b1, 1'b0);
      adv();
    end
    sample(1'b1, 1'b1, 1'b1);
    chk("flush_rd_addr",    32'(buf_rd_addr), 32'd2);
    chk("flush_dout_valid", 32'(dout_valid),  32'd0);
    chk("flush_wr_en",      32'(buf_wr_en),   32'd0);
    chk("flush_din_ready",  32'(din_ready),   32'd0);
    chk("flush_done",       32'(frame_done),  32'd0);
    adv();
    sample(1'b0, 1'b1, 1'b0);
    chk("post_flush_busy",      32'(busy),      32'd0);
    chk("post_flush_din_ready", 32'(din_ready), 32'd1);
    chk("post_flush_frame_cnt", 32'(frame_cnt), 32'd0);
    adv();
    run_frame(1'b0, "after_flush");
    sample(1'b0, 1'b1, 1'b0);
    chk("after_flush_frame_cnt", 32'(frame_cnt), 32'd1);
    adv();

    // Five back-to-back frames from reset: frame_cnt 1,2,3,0,1, period 12 cycles
    do_reset();
    for (int f = 0; f < 5; f++) push_frame();
    sb_on     = 1'b1;
    done_cnt  = 0;
    last_done = -1;
    pend      = 1'b0;
    for (int c = 0; c < 80 && done_cnt < 5; c++) begin
      sample(1'b1, 1'b1, 1'b0);
      if (pend) begin
        chk($sformatf("b2b_frame_cnt%0d", done_cnt), 32'(frame_cnt), 32'(exp_fc[done_cnt-1]));
        pend = 1'b0;
      end
      if (frame_done) begin
        if (done_cnt > 0) chk("b2b_period", 32'(c - last_done), 32'd12);
        last_done = c;
        done_cnt++;
        pend = 1'b1;
      end
      adv();
    end
    sample(1'b0, 1'b1, 1'b0);
    if (pend) chk("b2b_frame_cnt_last", 32'(frame_cnt), 32'(exp_fc[4]));
    chk("b2b_done_count", 32'(done_cnt), 32'd5);
    adv();
    chk_sb_empty("b2b");
    sb_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
